// File: rtl/halfadd_arb_pkg.sv
// Shared types and constants for the half-adder arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package halfadd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/half_adder_vec.sv
// Bitwise half adder across a W-bit vector: sum = a ^ b, carry = a & b.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module half_adder_vec #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    // Per-bit sum and carry with no ripple between bit positions.
    always_comb begin
        sum   = a ^ b;
        carry = a & b;
    end

endmodule

// File: rtl/halfadd_arbiter.sv
// Round-robin share of one half-adder datapath among N_REQ requesters.
// Latency: grant in cycle t, response valid at t+2; one op per 3 cycles at best.
// Backpressure: response held stable until rsp_ready; no new grant until the cycle after the handshake.
module halfadd_arbiter
    import halfadd_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   a_flat,
    input  logic [N_REQ*W-1:0]   b_flat,
    output logic [N_REQ-1:0]     gnt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic [W-1:0]         rsp_carry,
    output logic [COUNT_W-1:0]   op_count
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [IDW-1:0]       last_gnt_q;
    logic [IDW-1:0]       cur_id;
    logic [W-1:0]         op_a;
    logic [W-1:0]         op_b;
    logic [COUNT_W-1:0]   op_count_q;

    logic [IDW-1:0]       pick_idx;
    logic [W-1:0]         pick_a;
    logic [W-1:0]         pick_b;
    logic                 take;
    logic [W-1:0]         ha_sum;
    logic [W-1:0]         ha_carry;

    // First set request bit searching upward from the slot after the last
    // winner, wrapping at N_REQ. The last winner itself is checked last, so a
    // requester that keeps req high drops to lowest priority.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   last);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] cand;
        logic           found;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last) + k) % N_REQ);
            if (!found && r[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign op_count = op_count_q;

    // Select the candidate winner and its operand pair from the flat buses.
    always_comb begin
        pick_idx = rr_pick(req, last_gnt_q);
        pick_a   = a_flat[int'(pick_idx)*W +: W];
        pick_b   = b_flat[int'(pick_idx)*W +: W];
    end

    // Next-state and grant decode; grant only ever leaves IDLE.
    always_comb begin
        state_d = state_q;
        gnt     = '0;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt[pick_idx] = 1'b1;
                    take          = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    half_adder_vec #(.W(W)) u_ha (
        .a     (op_a),
        .b     (op_b),
        .sum   (ha_sum),
        .carry (ha_carry)
    );

    // Operand capture on grant, result registration in EXEC, handshake in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= IDW'(N_REQ - 1);
            cur_id     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_carry  <= '0;
            op_count_q <= '0;
        end else begin
            if (take) begin
                op_a       <= pick_a;
                op_b       <= pick_b;
                cur_id     <= pick_idx;
                last_gnt_q <= pick_idx;
            end
            if (state_q == EXEC) begin
                rsp_sum   <= ha_sum;
                rsp_carry <= ha_carry;
                rsp_id    <= cur_id;
                rsp_valid <= 1'b1;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid  <= 1'b0;
                op_count_q <= op_count_q + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_halfadd_arbiter.sv
// Scoreboard bench for halfadd_arbiter: directed cases plus random traffic.
// Grant and valid timing predicted per cycle from an operation-level model.
// Responses checked by an independent monitor popping an expectation queue.
module tb_halfadd_arbiter;

    localparam int NR  = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   sum;
        logic [W-1:0]   carry;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*W-1:0]   a_flat;
    logic [NR*W-1:0]   b_flat;
    logic [NR-1:0]     gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic [W-1:0]      rsp_carry;
    logic [15:0]       op_count;

    always #5 clk = ~clk;

    halfadd_arbiter #(.N_REQ(NR), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .op_count  (op_count)
    );

    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] a_arr [NR];
    logic [W-1:0] b_arr [NR];

    // Operation-level model state.
    bit          m_busy;
    int          m_age;
    int          m_last;
    logic [NR-1:0] m_gnt;
    rsp_t        sb[$];
    logic [15:0] exp_count = 16'd0;
    bit          hold_prev = 1'b0;
    rsp_t        prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pick(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_age     = 0;
        m_last    = NR - 1;
        m_gnt     = '0;
        sb.delete();
        exp_count = 16'd0;
        hold_prev = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check grant/valid against the model.
    task automatic step(input logic [NR-1:0] r, input logic rdy);
        logic [NR-1:0] eg;
        logic          ev;
        int            p;
        rsp_t          e;
        @(negedge clk);
        req       = r;
        rsp_ready = rdy;
        for (int i = 0; i < NR; i++) begin
            a_flat[i*W +: W] = a_arr[i];
            b_flat[i*W +: W] = b_arr[i];
        end
        #1;
        ev = m_busy && (m_age >= 2);
        eg = '0;
        p  = -1;
        if (!m_busy && (|r)) begin
            p     = ref_pick(r, m_last);
            eg[p] = 1'b1;
        end
        check("gnt", 32'(gnt), 32'(eg));
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        m_gnt = eg;
        if (m_busy) begin
            if (ev && rdy) m_busy = 1'b0;
            else           m_age++;
        end else if (p >= 0) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_last  = p;
            e.id    = IDW'(p);
            e.sum   = a_arr[p] ^ b_arr[p];
            e.carry = a_arr[p] & b_arr[p];
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        rsp_ready = 1'b0;
        model_reset();
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_sum", 32'(rsp_sum), 32'd0);
        check("rst_carry", 32'(rsp_carry), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step('0, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold stability and op_count.
    initial begin
        rsp_t got;
        forever begin
            @(negedge clk);
            #2;
            check("op_count", 32'(op_count), 32'(exp_count));
            got.id    = rsp_id;
            got.sum   = rsp_sum;
            got.carry = rsp_carry;
            if (hold_prev) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_data", 32'(got), 32'(prev));
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d sum %0h carry %0h, required no response",
                             rsp_id, rsp_sum, rsp_carry);
                end else begin
                    errors += (got !== sb[0]) ? 1 : 0;
                    if (got !== sb[0])
                        $display("FAIL rsp_data: got %0h required %0h", got, sb[0]);
                    void'(sb.pop_front());
                end
                exp_count++;
                hold_prev = 1'b0;
            end else if (rsp_valid) begin
                hold_prev = 1'b1;
                prev      = got;
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        logic [NR-1:0] cur_req;
        rst_n     = 1'b0;
        req       = '0;
        rsp_ready = 1'b0;
        a_flat    = '0;
        b_flat    = '0;
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        model_reset();
        @(negedge clk);
        #1;
        check("init_gnt", 32'(gnt), 32'd0);
        check("init_valid", 32'(rsp_valid), 32'd0);
        check("init_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request.
        a_arr[0] = 8'hA5;
        b_arr[0] = 8'h0F;
        step(4'b0001, 1'b1);
        check("single_gnt", 32'(gnt), 32'h1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd0);
        check("single_sum", 32'(rsp_sum), 32'hAA);
        check("single_carry", 32'(rsp_carry), 32'h05);
        step(4'b0000, 1'b1);
        check("single_count", 32'(op_count), 32'd1);

        // All four from reset: grants 0,1,2,3 every third cycle.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = 8'($urandom);
            b_arr[i] = 8'($urandom);
        end
        for (int k = 0; k < 12; k++) begin
            step(4'b1111, 1'b1);
            if (k % 3 == 0) check("rr_order", 32'(gnt), 32'(1 << (k / 3)));
            if (k % 3 == 2) check("rr_id", 32'(rsp_id), 32'(k / 3));
        end

        // Fairness: after 2, requests from 1 and 3 go to 3 then 1.
        step(4'b0100, 1'b1);
        check("fair_first", 32'(gnt), 32'h4);
        for (int k = 1; k <= 6; k++) begin
            step(4'b1010, 1'b1);
            if (k == 3) check("fair_second", 32'(gnt), 32'h8);
            if (k == 6) check("fair_third", 32'(gnt), 32'h2);
        end
        drain();

        // Backpressure: five stalled cycles in RESP.
        a_arr[2] = 8'h3C;
        b_arr[2] = 8'hF0;
        step(4'b0100, 1'b1);
        step(4'b1001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(4'b1001, 1'b0);
            check("bp_gnt", 32'(gnt), 32'd0);
            check("bp_sum", 32'(rsp_sum), 32'hCC);
            check("bp_carry", 32'(rsp_carry), 32'h30);
            check("bp_id", 32'(rsp_id), 32'd2);
        end
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b1);
        check("bp_next_gnt", 32'(gnt), 32'h8);
        drain();

        // Reset in the middle of EXEC: operation discarded, requester 0 first.
        step(4'b0010, 1'b1);
        check("mid_gnt", 32'(gnt), 32'h2);
        do_reset();
        step(4'b1111, 1'b1);
        check("post_rst_gnt", 32'(gnt), 32'h1);
        drain();

        // Counter wrap via preload.
        @(negedge clk);
        dut.op_count_q = 16'hFFFE;
        exp_count      = 16'hFFFE;
        a_arr[0] = 8'h11;
        b_arr[0] = 8'h33;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("wrap_ffff", 32'(op_count), 32'hFFFF);
        a_arr[0] = 8'hFF;
        b_arr[0] = 8'h81;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("wrap_sum", 32'(rsp_sum), 32'h7E);
        step(4'b0000, 1'b1);
        check("wrap_zero", 32'(op_count), 32'h0000);

        // Random traffic obeying requester rules.
        cur_req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (cur_req[i] && !m_gnt[i]) begin
                    if ($urandom_range(0, 19) == 0) cur_req[i] = 1'b0;
                end else begin
                    cur_req[i] = ($urandom_range(0, 2) != 0);
                    a_arr[i]   = 8'($urandom);
                    b_arr[i]   = 8'($urandom);
                end
            end
            step(cur_req, $urandom_range(0, 3) != 0);
        end
        drain();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
